// File: rtl/pwm_ramp_controller_if.sv
// Control/status bundle between the register file, the ramp controller and the PWM.
// The master drives target/step/rate/enable and period_end; the slave returns duty and status.
interface pwm_ramp_controller_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV_W = 8
);
   logic             enable;
   logic [WIDTH-1:0] target;
   logic             target_load;
   logic [3:0]       step;
   logic [DIV_W-1:0] rate_div;
   logic             period_end;
   logic [WIDTH-1:0] duty_out;
   logic             busy;
   logic             done;

   modport master (
      output enable, target, target_load, step, rate_div, period_end,
      input  duty_out, busy, done
   );

   modport slave (
      input  enable, target, target_load, step, rate_div, period_end,
      output duty_out, busy, done
   );
endinterface

// File: rtl/pwm_ramp_controller.sv
// Walks the PWM duty cycle toward a loaded target in clamped steps, one step every
// rate_div+1 PWM periods, so duty only changes at period boundaries.
module pwm_ramp_controller #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV_W = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   pwm_ramp_controller_if.slave  ctrl_if
);
   localparam int unsigned EXT_W = WIDTH + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_e;

   state_e             state_q,  state_d;
   logic [WIDTH-1:0]   duty_q,   duty_d;
   logic [WIDTH-1:0]   target_q, target_d;
   logic [DIV_W-1:0]   divcnt_q, divcnt_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;

   logic [EXT_W-1:0]   step_ext_c;
   logic [EXT_W-1:0]   sum_c;
   logic [EXT_W-1:0]   diff_c;
   logic [WIDTH-1:0]   stepped_c;

   // One extra bit keeps the add/subtract from wrapping before the clamp.
   always_comb begin
      step_ext_c = (ctrl_if.step == 4'd0) ? EXT_W'(1) : EXT_W'(ctrl_if.step);
      sum_c      = {1'b0, duty_q} + step_ext_c;
      diff_c     = {1'b0, duty_q} - step_ext_c;
      if (state_q == DOWN) begin
         stepped_c = (diff_c[WIDTH] || (diff_c[WIDTH-1:0] <= target_q)) ? target_q
                                                                        : diff_c[WIDTH-1:0];
      end else begin
         stepped_c = (sum_c >= {1'b0, target_q}) ? target_q : sum_c[WIDTH-1:0];
      end
   end

   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      target_d = target_q;
      divcnt_d = divcnt_q;
      done_d   = 1'b0;

      if (!ctrl_if.enable) begin
         state_d  = IDLE;
         divcnt_d = '0;
         if (ctrl_if.target_load) target_d = ctrl_if.target;
      end else if (ctrl_if.target_load) begin
         // Loads (including retargets mid-ramp) pick direction against the present duty.
         target_d = ctrl_if.target;
         divcnt_d = '0;
         if (ctrl_if.target > duty_q) begin
            state_d = UP;
         end else if (ctrl_if.target < duty_q) begin
            state_d = DOWN;
         end else begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end else begin
         case (state_q)
            IDLE: begin
               divcnt_d = '0;
               // Resume after enable returns with a target still outstanding.
               if (target_q > duty_q)      state_d = UP;
               else if (target_q < duty_q) state_d = DOWN;
            end
            UP, DOWN: begin
               if (ctrl_if.period_end) begin
                  if (divcnt_q == ctrl_if.rate_div) begin
                     divcnt_d = '0;
                     duty_d   = stepped_c;
                     if (stepped_c == target_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end
                  end else begin
                     divcnt_d = divcnt_q + DIV_W'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         duty_q   <= '0;
         target_q <= '0;
         divcnt_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         target_q <= target_d;
         divcnt_q <= divcnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign ctrl_if.duty_out = duty_q;
   assign ctrl_if.busy     = busy_q;
   assign ctrl_if.done     = done_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed and randomized bench for pwm_ramp_controller, checked every cycle against
// an arithmetic model of the ramp rules (min/max clamping, period counting).
module tb_pwm_ramp_controller;
   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   // Reference model state
   int m_duty, m_target, m_periods;
   bit m_ramp, m_done;

   pwm_ramp_controller_if #(.WIDTH(8), .DIV_W(8)) bus ();

   pwm_ramp_controller #(.WIDTH(8), .DIV_W(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ctrl_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_duty = 0; m_target = 0; m_periods = 0; m_ramp = 0; m_done = 0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      int s;
      m_done = 0;
      if (!rst_n) begin
         model_reset();
      end else if (!bus.enable) begin
         m_ramp = 0;
         m_periods = 0;
         if (bus.target_load) m_target = int'(bus.target);
      end else if (bus.target_load) begin
         m_target  = int'(bus.target);
         m_periods = 0;
         m_ramp    = (m_target != m_duty);
         m_done    = (m_target == m_duty);
      end else if (m_ramp) begin
         if (bus.period_end) begin
            if (m_periods == int'(bus.rate_div)) begin
               s = (bus.step == 0) ? 1 : int'(bus.step);
               if (m_target > m_duty) m_duty = (m_duty + s > m_target) ? m_target : m_duty + s;
               else                   m_duty = (m_duty - s < m_target) ? m_target : m_duty - s;
               m_periods = 0;
               if (m_duty == m_target) begin
                  m_ramp = 0;
                  m_done = 1;
               end
            end else begin
               m_periods = (m_periods + 1) % 256;
            end
         end
      end else if (m_target != m_duty) begin
         m_ramp = 1;
         m_periods = 0;
      end
   endtask

   task automatic tick(input bit pe);
      bus.period_end = pe;
      model_step();
      @(posedge clk);
      #1;
      chk("duty", 32'(bus.duty_out), 32'(m_duty));
      chk("busy", 32'(bus.busy), 32'(m_ramp));
      chk("done", 32'(bus.done), 32'(m_done));
      bus.target_load = 1'b0;
      bus.period_end  = 1'b0;
   endtask

   task automatic do_load(input int t, input int s, input int r);
      bus.target      = 8'(t);
      bus.step        = 4'(s);
      bus.rate_div    = 8'(r);
      bus.target_load = 1'b1;
      tick(1'b0);
   endtask

   task automatic run_to_idle(input int maxn, output int dcount);
      int n;
      n = 0;
      dcount = 0;
      while (m_ramp && n < maxn) begin
         tick(1'b1);
         if (bus.done === 1'b1) dcount++;
         tick(1'b0);
         n++;
      end
      chk("ramp_within_budget", 32'(n < maxn), 32'd1);
   endtask

   initial begin
      int dc;
      rst_n = 1'b0;
      bus.enable = 1'b0; bus.target = '0; bus.target_load = 1'b0;
      bus.step = '0; bus.rate_div = '0; bus.period_end = 1'b0;
      model_reset();
      tick(1'b0);
      tick(1'b0);
      rst_n = 1'b1;
      bus.enable = 1'b1;
      tick(1'b1);
      chk("reset_duty", 32'(bus.duty_out), 32'd0);

      // 1: 0 -> 100 in steps of 10, one step per period
      do_load(100, 10, 0);
      chk("t1_busy", 32'(bus.busy), 32'd1);
      run_to_idle(50, dc);
      chk("t1_final", 32'(bus.duty_out), 32'd100);
      chk("t1_done_count", 32'(dc), 32'd1);

      // 2: clamping at the top of range and at the target below
      do_load(250, 15, 0);
      run_to_idle(50, dc);
      do_load(255, 15, 0);
      run_to_idle(50, dc);
      chk("t2_no_wrap", 32'(bus.duty_out), 32'd255);
      do_load(10, 15, 0);
      run_to_idle(50, dc);
      do_load(3, 15, 0);
      run_to_idle(50, dc);
      chk("t2_floor", 32'(bus.duty_out), 32'd3);

      // 3: rate divider, step only on every 4th period_end
      do_load(0, 15, 0);
      run_to_idle(50, dc);
      do_load(2, 1, 3);
      for (int i = 1; i <= 8; i++) begin
         tick(1'b1);
         if (i == 3) chk("t3_pe3", 32'(bus.duty_out), 32'd0);
         if (i == 4) chk("t3_pe4", 32'(bus.duty_out), 32'd1);
         if (i == 7) chk("t3_pe7", 32'(bus.duty_out), 32'd1);
         if (i == 8) chk("t3_pe8_done", 32'(bus.done), 32'd1);
         tick(1'b0);
      end
      chk("t3_final", 32'(bus.duty_out), 32'd2);

      // 4: retarget downward mid-ramp
      do_load(0, 8, 0);
      run_to_idle(50, dc);
      do_load(200, 8, 0);
      for (int i = 0; i < 8; i++) begin
         tick(1'b1);
         tick(1'b0);
      end
      chk("t4_mid", 32'(bus.duty_out), 32'd64);
      do_load(32, 8, 0);
      run_to_idle(50, dc);
      chk("t4_final", 32'(bus.duty_out), 32'd32);
      chk("t4_done_count", 32'(dc), 32'd1);

      // 5: freeze with enable low, then resume
      do_load(0, 8, 0);
      run_to_idle(50, dc);
      do_load(80, 8, 0);
      for (int i = 0; i < 5; i++) begin
         tick(1'b1);
         tick(1'b0);
      end
      bus.enable = 1'b0;
      tick(1'b0);
      chk("t5_frozen_busy", 32'(bus.busy), 32'd0);
      for (int i = 0; i < 4; i++) tick(1'b1);
      chk("t5_frozen_duty", 32'(bus.duty_out), 32'd40);
      bus.enable = 1'b1;
      tick(1'b0);
      chk("t5_resume_busy", 32'(bus.busy), 32'd1);
      run_to_idle(50, dc);
      chk("t5_final", 32'(bus.duty_out), 32'd80);

      // 6: asynchronous reset between edges, then an equal load
      do_load(200, 8, 0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1);
         tick(1'b0);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t6_async_duty", 32'(bus.duty_out), 32'd0);
      chk("t6_async_busy", 32'(bus.busy), 32'd0);
      tick(1'b1);
      rst_n = 1'b1;
      do_load(0, 1, 0);
      chk("t6_eq_done", 32'(bus.done), 32'd1);
      chk("t6_eq_busy", 32'(bus.busy), 32'd0);
      tick(1'b0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         bus.enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 11) == 0) begin
            bus.target      = 8'($urandom_range(0, 255));
            bus.target_load = 1'b1;
         end
         bus.step = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) bus.rate_div = 8'($urandom_range(0, 3));
         tick(bit'($urandom_range(0, 2) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
